mem_responder: RTL



---
 rtl/mem_responder_pkg.sv | 18 +
 rtl/mem_responder_io_fifo.sv | 53 +++++
 rtl/mem_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared address map and region decode for mem_responder.
// IO space only exists in builds with MEM_RESPONDER_IO_EN defined.
package mem_responder_pkg;

  localparam logic [31:0] IO_BASE   = 32'h0003_0000;
  localparam logic [31:0] IO_STATUS = 32'h0003_0004;

  typedef enum logic [1:0] {
    REGION_RAM = 2'b00,
    REGION_IO  = 2'b11
  } region_e;

  // Only address bits [17:16] take part in the region decode.
  function automatic region_e region_of(input logic [31:0] addr);
    return (addr[17:16] == 2'b11) ? REGION_IO : REGION_RAM;
  endfunction

endpackage

// File: rtl/mem_responder_io_fifo.sv
// Circular byte FIFO for the IO output path (module mem_io_fifo).
// A pop frees the slot a same-cycle push uses, so push+pop when full both happen.
module mem_io_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Byte RAM responder with a fixed-latency read pipeline.
// Define MEM_RESPONDER_IO_EN to add the IO output FIFO and status register.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 17,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned IO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ram_addr,
  input  logic        ram_writing,
  input  logic [7:0]  ram_data,
  output logic [7:0]  ram_loaded_data,
  output logic        io_out_valid,
  output logic [7:0]  io_out_data,
  input  logic        io_out_ready,
  output logic        io_overflow
);

  logic [7:0] mem [2**ADDR_WIDTH];
  logic [7:0] ram_q;
  logic       slot_src;
  logic [7:0] slot_val;
  logic [7:0] stage0;
  logic [7:0] dly [READ_LATENCY];
  logic       is_io;
  logic       ram_we;
  logic [7:0] io_rd_val;
  logic       unused_bits;

`ifdef MEM_RESPONDER_IO_EN
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      overflow;
  logic [$clog2(IO_DEPTH):0] fifo_count;

  assign is_io     = (region_of(ram_addr) == REGION_IO);
  assign push      = !rst && ram_writing && (ram_addr == IO_BASE);
  assign pop       = io_out_ready && !fifo_empty;
  assign io_rd_val = (ram_addr == IO_STATUS) ? {6'b0, overflow, fifo_full} : '0;

  mem_io_fifo #(
    .DEPTH (IO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (ram_data),
    .pop       (pop),
    .pop_data  (io_out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst)                                overflow <= 1'b0;
    else if (push && fifo_full && !pop)     overflow <= 1'b1;
  end

  assign io_out_valid = (fifo_count != '0);
  assign io_overflow  = overflow;
  assign unused_bits  = ^ram_addr;
`else
  assign is_io        = 1'b0;
  assign io_rd_val    = '0;
  assign io_out_valid = 1'b0;
  assign io_out_data  = '0;
  assign io_overflow  = 1'b0;
  assign unused_bits  = ^{io_out_ready, ram_addr};
`endif

  assign ram_we = !rst && ram_writing && !is_io;

  // RAM array has no reset; its registered read is only used when slot_src says so.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr[ADDR_WIDTH-1:0]] <= ram_data;
    ram_q <= mem[ram_addr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_src <= 1'b0;
      slot_val <= '0;
    end else if (ram_writing) begin
      slot_src <= 1'b0;
      slot_val <= '0;
    end else if (is_io) begin
      slot_src <= 1'b0;
      slot_val <= io_rd_val;
    end else begin
      slot_src <= 1'b1;
      slot_val <= '0;
    end
  end

  assign stage0 = slot_src ? ram_q : slot_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) dly[i] <= '0;
    end else begin
      dly[0] <= stage0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) dly[i] <= dly[i-1];
    end
  end

  assign ram_loaded_data = dly[READ_LATENCY-1];

endmodule
